// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
//   Shared definitions for the button path: FSM state encoding for the gesture
//   decoder, default timing constants at a 50 MHz system clock, and the packed
//   event record used to register the one-cycle gesture pulses. The debouncer
//   and the application FSMs import the same constants so every block agrees
//   on what "long" and "double" mean.
// -----------------------------------------------------------------------------
package btn_pkg;

   // Gesture FSM state encoding. Kept as plain constants so legacy blocks that
   // compare raw state values keep working.
   typedef logic [2:0] btn_state_t;

   localparam btn_state_t ST_IDLE   = 3'd0;
   localparam btn_state_t ST_PRESS1 = 3'd1;
   localparam btn_state_t ST_LONG   = 3'd2;
   localparam btn_state_t ST_WAIT2  = 3'd3;
   localparam btn_state_t ST_PRESS2 = 3'd4;

   // Default timing at 50 MHz.
   localparam int DEF_CNT_W         = 26;
   localparam int DEF_LONG_CYCLES   = 25_000_000;  // 0.5 s hold
   localparam int DEF_DCLICK_CYCLES = 12_500_000;  // 0.25 s double-click window
   localparam int DEF_REPEAT_CYCLES = 5_000_000;  // 0.1 s auto-repeat period

   // One bit per single-cycle gesture event.
   typedef struct packed {
      logic press_evt;
      logic release_evt;
      logic short_evt;
      logic long_evt;
      logic dclick_evt;
      logic repeat_evt;
   } gesture_evt_t;

endpackage : btn_pkg

// File: rtl/btn_edge_detect.sv
// -----------------------------------------------------------------------------
// btn_edge_detect
//   Keeps the previous sample of a synchronous level and produces combinational
//   rise/fall strobes for the current sample. The previous-sample register
//   resets to 1, so a level that is already high when reset is released does
//   not look like a rising edge; it must be seen low first. Reusable for
//   switch inputs.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   i_level  in   clean level, synchronous to clk
//   o_rise   out  i_level is 1 and previous sample was 0
//   o_fall   out  i_level is 0 and previous sample was 1
// -----------------------------------------------------------------------------
module btn_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic i_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_prev;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev <= 1'b1;
      end else begin
         r_prev <= i_level;
      end
   end

   assign o_rise =  i_level & ~r_prev;
   assign o_fall = ~i_level &  r_prev;

endmodule : btn_edge_detect

// File: rtl/button_gesture_decoder.sv
// -----------------------------------------------------------------------------
// button_gesture_decoder
//   Classifies presses of a debounced button into one-cycle gesture events:
//   short press, long press, double click and auto-repeat while held. One
//   shared counter times every phase of the gesture; all outputs are
//   registered and pulse for exactly one cycle, the cycle after the sampling
//   edge that caused them.
//
// Parameters:
//   CNT_W          width of the shared timing counter
//   LONG_CYCLES    high samples after the press edge before long_press
//   DCLICK_CYCLES  window after release in which a new press is a double click
//   REPEAT_CYCLES  auto-repeat period after long_press
//   REPEAT_EN      1 enables repeat_pulse, 0 suppresses it
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   btn_in         in   debounced button level, 1 = pressed
//   press_pulse    out  accepted press edge
//   release_pulse  out  release edge of an accepted press
//   short_press    out  single press, released before long, no second press
//   long_press     out  hold reached LONG_CYCLES
//   double_click   out  second press edge inside the window
//   repeat_pulse   out  every REPEAT_CYCLES while held after long_press
//   hold_level     out  high from the long_press cycle until release
// -----------------------------------------------------------------------------
module button_gesture_decoder
   import btn_pkg::*;
#(
   parameter int CNT_W         = DEF_CNT_W,
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int DCLICK_CYCLES = DEF_DCLICK_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter bit REPEAT_EN     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_press,
   output logic long_press,
   output logic double_click,
   output logic repeat_pulse,
   output logic hold_level
);

   // --------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // --------------------------------------------------------------------------
   if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
      $error("button_gesture_decoder: CNT_W must be in 1..31");
   end
   if (LONG_CYCLES < 2 || LONG_CYCLES >= (1 << CNT_W)) begin : g_bad_long
      $error("button_gesture_decoder: LONG_CYCLES must be >= 2 and < 2**CNT_W");
   end
   if (DCLICK_CYCLES < 2 || DCLICK_CYCLES >= (1 << CNT_W)) begin : g_bad_dclick
      $error("button_gesture_decoder: DCLICK_CYCLES must be >= 2 and < 2**CNT_W");
   end
   if (REPEAT_CYCLES < 2 || REPEAT_CYCLES >= (1 << CNT_W)) begin : g_bad_repeat
      $error("button_gesture_decoder: REPEAT_CYCLES must be >= 2 and < 2**CNT_W");
   end

   // Terminal counts: the counter starts at 0 on the edge that enters a
   // state, so the event fires when it has counted N-1 further samples.
   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   // --------------------------------------------------------------------------
   // Edge detection
   // --------------------------------------------------------------------------
   logic w_rise;
   logic w_fall;

   btn_edge_detect u_edge (
      .clk     (clk),
      .rst     (rst),
      .i_level (btn_in),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   // --------------------------------------------------------------------------
   // State, shared counter and registered outputs
   // --------------------------------------------------------------------------
   btn_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   gesture_evt_t     r_evt;
   logic             r_hold;

   btn_state_t       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   gesture_evt_t     w_evt;
   logic             w_hold_nxt;

   // The pressed states are only entered on a high sample and left on the
   // first low one, so a low sample there is always a fall edge; likewise a
   // high sample in WAIT2 is always a rise edge. Using the strobes keeps the
   // edge definition in one place.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_evt       = '0;
      w_hold_nxt  = r_hold;

      unique case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_evt.press_evt = 1'b1;
               w_state_nxt     = ST_PRESS1;
               w_cnt_nxt       = '0;
            end
         end

         ST_PRESS1: begin
            // Release wins over the long threshold on the same sample.
            if (w_fall) begin
               w_evt.release_evt = 1'b1;
               w_state_nxt       = ST_WAIT2;
               w_cnt_nxt         = '0;
            end else if (r_cnt == LONG_LAST) begin
               w_evt.long_evt = 1'b1;
               w_hold_nxt     = 1'b1;
               w_state_nxt    = ST_LONG;
               w_cnt_nxt      = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end

         ST_LONG: begin
            // A long press ends without a short_press.
            if (w_fall) begin
               w_evt.release_evt = 1'b1;
               w_hold_nxt        = 1'b0;
               w_state_nxt       = ST_IDLE;
               w_cnt_nxt         = '0;
            end else if (r_cnt == REPEAT_LAST) begin
               // With repeat disabled the counter parks at the terminal value.
               if (REPEAT_EN) begin
                  w_evt.repeat_evt = 1'b1;
                  w_cnt_nxt        = '0;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end

         ST_WAIT2: begin
            // A press on the last window sample still counts as a double click.
            if (w_rise) begin
               w_evt.press_evt  = 1'b1;
               w_evt.dclick_evt = 1'b1;
               w_state_nxt      = ST_PRESS2;
               w_cnt_nxt        = '0;
            end else if (r_cnt == DCLICK_LAST) begin
               w_evt.short_evt = 1'b1;
               w_state_nxt     = ST_IDLE;
               w_cnt_nxt       = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end

         ST_PRESS2: begin
            // The second press of a double click is never timed.
            if (w_fall) begin
               w_evt.release_evt = 1'b1;
               w_state_nxt       = ST_IDLE;
               w_cnt_nxt         = '0;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_hold_nxt  = 1'b0;
         end
      endcase
   end

   // Reset aborts any gesture silently: outputs clear, no release or short
   // pulse is generated for the interrupted press.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_evt   <= '0;
         r_hold  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_evt   <= w_evt;
         r_hold  <= w_hold_nxt;
      end
   end

   assign press_pulse   = r_evt.press_evt;
   assign release_pulse = r_evt.release_evt;
   assign short_press   = r_evt.short_evt;
   assign long_press    = r_evt.long_evt;
   assign double_click  = r_evt.dclick_evt;
   assign repeat_pulse  = r_evt.repeat_evt;
   assign hold_level    = r_hold;

endmodule : button_gesture_decoder

// File: tb/tb_button_gesture_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_gesture_decoder
//   Two decoders (auto-repeat on and off) share clock, reset and button
//   stimulus. A timestamp-based gesture model predicts every output on every
//   cycle; directed scenarios add hand-computed pulse counts and spacings.
// -----------------------------------------------------------------------------
module tb_button_gesture_decoder;

   localparam int CW = 8;
   localparam int L  = 8;   // LONG_CYCLES
   localparam int D  = 6;   // DCLICK_CYCLES
   localparam int R  = 4;   // REPEAT_CYCLES

   // Output vector bit positions
   localparam int B_HOLD = 0, B_REP = 1, B_DCL = 2, B_LONG = 3,
                  B_SHORT = 4, B_REL = 5, B_PRESS = 6;

   logic clk = 1'b0;
   logic rst;
   logic btn_in;

   logic [6:0] d_out [2];

   button_gesture_decoder #(
      .CNT_W(CW), .LONG_CYCLES(L), .DCLICK_CYCLES(D),
      .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)
   ) dut_rep (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in),
      .press_pulse   (d_out[0][B_PRESS]),
      .release_pulse (d_out[0][B_REL]),
      .short_press   (d_out[0][B_SHORT]),
      .long_press    (d_out[0][B_LONG]),
      .double_click  (d_out[0][B_DCL]),
      .repeat_pulse  (d_out[0][B_REP]),
      .hold_level    (d_out[0][B_HOLD])
   );

   button_gesture_decoder #(
      .CNT_W(CW), .LONG_CYCLES(L), .DCLICK_CYCLES(D),
      .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)
   ) dut_norep (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in),
      .press_pulse   (d_out[1][B_PRESS]),
      .release_pulse (d_out[1][B_REL]),
      .short_press   (d_out[1][B_SHORT]),
      .long_press    (d_out[1][B_LONG]),
      .double_click  (d_out[1][B_DCL]),
      .repeat_pulse  (d_out[1][B_REP]),
      .hold_level    (d_out[1][B_HOLD])
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // --------------------------------------------------------------------------
   // Gesture model: tracks when the current press started, when long fired and
   // when the last single release happened, and derives events from elapsed
   // sample counts.
   // --------------------------------------------------------------------------
   typedef struct {
      bit held;      // an accepted press is in progress
      bit second;    // that press is the second of a double click
      bit longed;    // long_press already issued for this press
      bit waiting;   // released a single press, double-click window open
      bit prev;      // last sampled level
      int press_t;
      int long_t;
      int rel_t;
   } mdl_t;

   mdl_t       m [2];
   logic [6:0] exp_o [2];
   bit         rep_en [2] = '{1'b1, 1'b0};
   string      out_name [7] = '{"hold_level", "repeat_pulse", "double_click",
                                "long_press", "short_press", "release_pulse",
                                "press_pulse"};

   // Observed pulse statistics for the directed scenarios.
   int cyc = 0;
   int ev_cnt   [2][7];
   int ev_first [2][7];
   int ev_last  [2][7];

   task automatic clear_stats();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 7; k++) begin
            ev_cnt[d][k]   = 0;
            ev_first[d][k] = -1;
            ev_last[d][k]  = -1;
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         m[d]      = '{default: 0};
         m[d].prev = 1'b1;
         exp_o[d]  = '0;
      end
      clear_stats();
      forever begin
         @(posedge clk);
         for (int d = 0; d < 2; d++) begin
            logic [6:0] e;
            e = '0;
            if (rst) begin
               m[d]      = '{default: 0};
               m[d].prev = 1'b1;
            end else begin
               if (m[d].held) begin
                  if (!btn_in) begin
                     e[B_REL] = 1'b1;
                     m[d].held = 1'b0;
                     if (!m[d].longed && !m[d].second) begin
                        m[d].waiting = 1'b1;
                        m[d].rel_t   = cyc;
                     end
                     m[d].longed = 1'b0;
                  end else if (!m[d].second && !m[d].longed && cyc - m[d].press_t == L) begin
                     e[B_LONG]   = 1'b1;
                     m[d].longed = 1'b1;
                     m[d].long_t = cyc;
                  end else if (m[d].longed && rep_en[d] && (cyc - m[d].long_t) % R == 0) begin
                     e[B_REP] = 1'b1;
                  end
               end else if (m[d].waiting) begin
                  if (btn_in) begin
                     e[B_PRESS]   = 1'b1;
                     e[B_DCL]     = 1'b1;
                     m[d].held    = 1'b1;
                     m[d].second  = 1'b1;
                     m[d].waiting = 1'b0;
                  end else if (cyc - m[d].rel_t == D) begin
                     e[B_SHORT]   = 1'b1;
                     m[d].waiting = 1'b0;
                  end
               end else if (btn_in && !m[d].prev) begin
                  e[B_PRESS]    = 1'b1;
                  m[d].held     = 1'b1;
                  m[d].second   = 1'b0;
                  m[d].longed   = 1'b0;
                  m[d].press_t  = cyc;
               end
               m[d].prev = btn_in;
            end
            e[B_HOLD] = m[d].held && m[d].longed;
            exp_o[d]  = e;
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 7; k++) begin
               check($sformatf("d%0d.%s@%0d", d, out_name[k], cyc), d_out[d][k], exp_o[d][k]);
            end
            for (int k = 1; k < 7; k++) begin
               if (d_out[d][k] === 1'b1) begin
                  if (ev_cnt[d][k] == 0) ev_first[d][k] = cyc;
                  ev_cnt[d][k]++;
                  ev_last[d][k] = cyc;
               end
            end
         end
         cyc++;
      end
   end

   // Hold btn_in at b for n sampling edges (called on a falling edge).
   task automatic drive(input logic b, input int n);
      btn_in = b;
      repeat (n) @(negedge clk);
   endtask

   // --------------------------------------------------------------------------
   // Directed scenarios
   // --------------------------------------------------------------------------
   initial begin
      rst    = 1'b1;
      btn_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset.d0_outputs", d_out[0], 7'd0);
      check("reset.d1_outputs", d_out[1], 7'd0);
      drive(0, 2);

      // 1. Short press
      clear_stats();
      drive(1, 3); drive(0, 12);
      check("t1.press_cnt",   ev_cnt[0][B_PRESS], 1);
      check("t1.release_cnt", ev_cnt[0][B_REL],   1);
      check("t1.short_cnt",   ev_cnt[0][B_SHORT], 1);
      check("t1.long_cnt",    ev_cnt[0][B_LONG],  0);
      check("t1.dclick_cnt",  ev_cnt[0][B_DCL],   0);
      check("t1.repeat_cnt",  ev_cnt[0][B_REP],   0);
      check("t1.short_delay", ev_first[0][B_SHORT] - ev_last[0][B_REL], 6);

      // 2. Double click
      clear_stats();
      drive(1, 3); drive(0, 5); drive(1, 3); drive(0, 12);
      check("t2.press_cnt",   ev_cnt[0][B_PRESS], 2);
      check("t2.release_cnt", ev_cnt[0][B_REL],   2);
      check("t2.dclick_cnt",  ev_cnt[0][B_DCL],   1);
      check("t2.short_cnt",   ev_cnt[0][B_SHORT], 0);
      check("t2.dclick_at_press2", ev_last[0][B_DCL], ev_last[0][B_PRESS]);

      // 3a. Held exactly LONG_CYCLES samples: still a short press
      clear_stats();
      drive(1, 8); drive(0, 12);
      check("t3a.long_cnt",  ev_cnt[0][B_LONG],  0);
      check("t3a.short_cnt", ev_cnt[0][B_SHORT], 1);

      // 3b. Long press with auto-repeat
      clear_stats();
      drive(1, 25);
      check("t3b.d0_hold_high", d_out[0][B_HOLD], 1'b1);
      check("t3b.d1_hold_high", d_out[1][B_HOLD], 1'b1);
      drive(0, 3);
      check("t3b.d0_hold_low",   d_out[0][B_HOLD], 1'b0);
      check("t3b.long_cnt",      ev_cnt[0][B_LONG], 1);
      check("t3b.long_delay",    ev_first[0][B_LONG] - ev_first[0][B_PRESS], 8);
      check("t3b.repeat_cnt",    ev_cnt[0][B_REP], 4);
      check("t3b.first_repeat",  ev_first[0][B_REP] - ev_first[0][B_LONG], 4);
      check("t3b.last_repeat",   ev_last[0][B_REP] - ev_first[0][B_LONG], 16);
      check("t3b.short_cnt",     ev_cnt[0][B_SHORT], 0);
      check("t3b.release_cnt",   ev_cnt[0][B_REL], 1);
      // 6. Repeat disabled
      check("t6.long_cnt",       ev_cnt[1][B_LONG], 1);
      check("t6.repeat_cnt",     ev_cnt[1][B_REP], 0);
      check("t6.release_cnt",    ev_cnt[1][B_REL], 1);
      drive(0, 6);

      // 4a. Press on the last window sample: double click
      clear_stats();
      drive(1, 3); drive(0, 6); drive(1, 3); drive(0, 12);
      check("t4a.dclick_cnt", ev_cnt[0][B_DCL],   1);
      check("t4a.short_cnt",  ev_cnt[0][B_SHORT], 0);

      // 4b. Press one sample after the window: short, then a fresh press
      clear_stats();
      drive(1, 3); drive(0, 7); drive(1, 3); drive(0, 12);
      check("t4b.dclick_cnt",    ev_cnt[0][B_DCL],   0);
      check("t4b.press_cnt",     ev_cnt[0][B_PRESS], 2);
      check("t4b.short_cnt",     ev_cnt[0][B_SHORT], 2);
      check("t4b.short_then_press", ev_first[0][B_SHORT] + 1, ev_last[0][B_PRESS]);

      // 5. Reset in the middle of a long hold
      clear_stats();
      drive(1, 12);
      check("t5.hold_before_rst", d_out[0][B_HOLD], 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5.d0_after_rst", d_out[0], 7'd0);
      check("t5.d1_after_rst", d_out[1], 7'd0);
      clear_stats();
      drive(1, 5); drive(0, 4);
      check("t5.no_press_held", ev_cnt[0][B_PRESS], 0);
      check("t5.no_release",    ev_cnt[0][B_REL],   0);
      drive(1, 3); drive(0, 12);
      check("t5.press_cnt",   ev_cnt[0][B_PRESS], 1);
      check("t5.release_cnt", ev_cnt[0][B_REL],   1);
      check("t5.short_cnt",   ev_cnt[0][B_SHORT], 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_button_gesture_decoder
